// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, synchronous-ROM request tracking, one
// registered output stage with valid/ready handshake, redirect/flush and field decode.
module fetch_unit #(
    parameter int PC_WIDTH  = 8,
    parameter int RESET_PC  = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [PC_WIDTH-1:0]  rom_addr,
    input  logic [31:0]          rom_data,
    input  logic                 redirect_valid,
    input  logic [PC_WIDTH-1:0]  redirect_pc,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [31:0]          out_instr,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic [PC_WIDTH-1:0]  out_pc_next,
    output logic [4:0]           rd,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [11:0]          imm,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    localparam logic [PC_WIDTH-1:0] RESET_PC_W = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);

    logic [PC_WIDTH-1:0]  pc;
    logic                 req_valid;
    logic [PC_WIDTH-1:0]  req_pc;
    logic                 out_valid_r;
    logic [31:0]          out_instr_r;
    logic [PC_WIDTH-1:0]  out_pc_r;
    logic [CNT_WIDTH-1:0] fetch_count_r;

    logic                 advance;
    logic                 handshake;
    logic [PC_WIDTH-1:0]  redirect_tgt;

    assign advance      = !out_valid_r || out_ready;
    assign handshake    = out_valid_r && out_ready;
    assign redirect_tgt = {redirect_pc[PC_WIDTH-1:2], 2'b00};

    // While stalled the ROM re-reads req_pc so rom_data stays aligned with it.
    always_comb begin
        rom_addr = req_pc;
        if (redirect_valid) begin
            rom_addr = redirect_tgt;
        end else if (advance) begin
            rom_addr = pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_PC_W;
            req_valid     <= 1'b0;
            req_pc        <= '0;
            out_valid_r   <= 1'b0;
            out_instr_r   <= '0;
            out_pc_r      <= '0;
            fetch_count_r <= '0;
        end else begin
            if (handshake && (fetch_count_r != '1)) begin
                fetch_count_r <= fetch_count_r + 1'b1;
            end
            if (redirect_valid) begin
                // Flush the output stage; a handshake on this edge is still counted above.
                out_valid_r <= 1'b0;
                req_valid   <= 1'b1;
                req_pc      <= redirect_tgt;
                pc          <= redirect_tgt + PC_STEP;
            end else if (advance) begin
                out_valid_r <= req_valid;
                out_instr_r <= rom_data;
                out_pc_r    <= req_pc;
                req_valid   <= 1'b1;
                req_pc      <= pc;
                pc          <= pc + PC_STEP;
            end
        end
    end

    assign out_valid   = out_valid_r;
    assign out_instr   = out_instr_r;
    assign out_pc      = out_pc_r;
    assign out_pc_next = out_pc_r + PC_STEP;
    assign rd          = out_instr_r[11:7];
    assign rs1         = out_instr_r[19:15];
    assign rs2         = out_instr_r[24:20];
    assign imm         = out_instr_r[31:20];
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model, expected-PC scoreboard queue and
// a small valid/count reference model, checked with immediate assertions.
module tb_fetch_unit;

    localparam int PW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] rom_addr;
    logic [31:0]   rom_data = 32'h0;
    logic          redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic          out_ready;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [PW-1:0] out_pc;
    logic [PW-1:0] out_pc_next;
    logic [4:0]    rd, rs1, rs2;
    logic [11:0]   imm;
    logic [CW-1:0] fetch_count;

    fetch_unit #(.PC_WIDTH(PW), .RESET_PC(0), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_next(out_pc_next), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [PW-1:0] a);
        if (a == 8'h48) return 32'h00A30293;
        return 32'h1000 + 32'(a[PW-1:2]);
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [PW-1:0] q[$];
    logic          exp_valid;
    logic          exp_req;
    int            exp_cnt;
    logic [31:0]   held_instr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_q(input logic [PW-1:0] start);
        q.delete();
        for (int i = 0; i < 64; i++) q.push_back(start + PW'(4 * i));
    endtask

    task automatic reset_model();
        exp_valid = 1'b0;
        exp_req   = 1'b0;
        exp_cnt   = 0;
        fill_q('0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_pc"}, 32'(out_pc), 32'h0);
        chk({tag, "_instr"}, out_instr, 32'h0);
        chk({tag, "_pc_next"}, 32'(out_pc_next), 32'h4);
        chk({tag, "_count"}, 32'(fetch_count), 32'h0);
        chk({tag, "_fields"}, {rd, rs1, rs2, imm[11:0]}, 32'h0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
    endtask

    task automatic check_outputs();
        logic [31:0] ei;
        chk("valid", 32'(out_valid), 32'(exp_valid));
        chk("count", 32'(fetch_count), 32'(exp_cnt));
        if (exp_valid) begin
            chk("queue_nonempty", 32'(q.size() != 0), 32'h1);
            if (q.size() != 0) begin
                ei = rom_fn(q[0]);
                chk("pc", 32'(out_pc), 32'(q[0]));
                chk("instr", out_instr, ei);
                chk("pc_next", 32'(out_pc_next), 32'(PW'(q[0] + PW'(4))));
                chk("rd", 32'(rd), 32'(ei[11:7]));
                chk("rs1", 32'(rs1), 32'(ei[19:15]));
                chk("rs2", 32'(rs2), 32'(ei[24:20]));
                chk("imm", 32'(imm), 32'(ei[31:20]));
            end
        end
    endtask

    // One clock: model the edge from bench-driven inputs, then check #1 after it.
    task automatic tick();
        logic          hs, redir, adv;
        logic [PW-1:0] tgt;
        hs    = exp_valid && out_ready;
        redir = redirect_valid;
        adv   = !exp_valid || out_ready;
        tgt   = {redirect_pc[PW-1:2], 2'b00};
        @(posedge clk);
        #1;
        if (hs) begin
            if (q.size() != 0) void'(q.pop_front());
            if (exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
        if (redir) begin
            exp_valid = 1'b0;
            exp_req   = 1'b1;
            fill_q(tgt);
        end else if (adv) begin
            exp_valid = exp_req;
            exp_req   = 1'b1;
        end
        check_outputs();
    endtask

    initial begin
        reset          = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        reset_model();
        #2;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        reset_model();

        tick();
        chk("first_bubble", 32'(out_valid), 32'h0);
        tick();
        chk("first_pc", 32'(out_pc), 32'h0);
        chk("first_instr", out_instr, 32'h1000);
        tick();
        tick();
        chk("pc8", 32'(out_pc), 32'h8);

        out_ready = 1'b0;
        #1;
        chk("stall_rom_addr", 32'(rom_addr), 32'hC);
        held_instr = out_instr;
        repeat (3) begin
            tick();
            chk("stall_pc", 32'(out_pc), 32'h8);
            chk("stall_instr", out_instr, held_instr);
            chk("stall_rom_addr_hold", 32'(rom_addr), 32'hC);
        end
        out_ready = 1'b1;
        tick();
        chk("resume_pc12", 32'(out_pc), 32'hC);
        tick();
        chk("resume_pc16", 32'(out_pc), 32'h10);

        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h43;
        #1;
        chk("redirect_rom_addr", 32'(rom_addr), 32'h40);
        tick();
        redirect_valid = 1'b0;
        chk("redirect_bubble", 32'(out_valid), 32'h0);
        tick();
        chk("redirect_target", 32'(out_pc), 32'h40);
        out_ready = 1'b1;
        tick();
        chk("redirect_next", 32'(out_pc), 32'h44);
        tick();
        chk("decode_rd", 32'(rd), 32'd5);
        chk("decode_rs1", 32'(rs1), 32'd6);
        chk("decode_rs2", 32'(rs2), 32'd10);
        chk("decode_imm", 32'(imm), 32'h00A);
        tick();

        redirect_valid = 1'b1;
        redirect_pc    = 8'hF8;
        tick();
        redirect_valid = 1'b0;
        chk("flush_with_ready", 32'(out_valid), 32'h0);
        tick();
        chk("wrap_f8", 32'(out_pc), 32'hF8);
        tick();
        chk("wrap_fc", 32'(out_pc), 32'hFC);
        chk("wrap_pc_next", 32'(out_pc_next), 32'h00);
        tick();
        chk("wrap_00", 32'(out_pc), 32'h00);
        tick();
        chk("wrap_04", 32'(out_pc), 32'h04);

        repeat (20) tick();
        chk("count_saturated", 32'(fetch_count), 32'hF);
        tick();
        chk("count_held", 32'(fetch_count), 32'hF);

        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        reset_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("rerun_bubble", 32'(out_valid), 32'h0);
        tick();
        chk("rerun_pc", 32'(out_pc), 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
